// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : UART transmitter fed by a small word FIFO. Each queued word
//                is sent as a start bit, the data bits LSB first, an optional
//                parity bit and one or two stop bits. The line idles high.
//  Ports       : Clock       - system clock, rising edge
//                Reset       - synchronous, active-high
//                DataIn      - word to transmit
//                DataInValid - producer offers DataIn this cycle
//                DataInReady - FIFO can take a word (low while full or in reset)
//                SOut        - registered serial line
//                Busy        - frame in progress or words still queued
//                FifoCount   - number of occupied FIFO entries
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int ClockFreq  = 100_000_000,
   parameter int BaudRate   = 115_200,
   parameter int DataWidth  = 8,
   parameter int ParityMode = 0,
   parameter int StopBits   = 1,
   parameter int FifoDepth  = 8
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic [DataWidth-1:0]       DataIn,
   input  logic                       DataInValid,
   output logic                       DataInReady,
   output logic                       SOut,
   output logic                       Busy,
   output logic [$clog2(FifoDepth):0] FifoCount
);

   localparam int SYMBOL_EDGE_TIME = ClockFreq / BaudRate;
   localparam int CNT_W   = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
   localparam int BIT_W   = $clog2(DataWidth + 1);
   localparam int ADDR_W  = $clog2(FifoDepth);
   localparam int COUNT_W = ADDR_W + 1;

   localparam logic [CNT_W-1:0]   LAST_CNT      = CNT_W'(SYMBOL_EDGE_TIME - 1);
   localparam logic [BIT_W-1:0]   LAST_DATA_BIT = BIT_W'(DataWidth - 1);
   localparam logic [BIT_W-1:0]   LAST_STOP_BIT = BIT_W'(StopBits - 1);
   localparam logic [COUNT_W-1:0] FULL_COUNT    = COUNT_W'(FifoDepth);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   // ------------------------------------------------------------------------
   // FIFO storage and bookkeeping
   // ------------------------------------------------------------------------
   logic [DataWidth-1:0] mem [FifoDepth];
   logic [ADDR_W-1:0]    wr_ptr;
   logic [ADDR_W-1:0]    rd_ptr;
   logic [COUNT_W-1:0]   count;
   logic                 push;
   logic                 pop;
   logic                 fifo_empty;
   logic [DataWidth-1:0] head_word;
   logic                 head_parity;

   // ------------------------------------------------------------------------
   // Transmit engine
   // ------------------------------------------------------------------------
   logic [2:0]           state;
   logic [2:0]           next_state;
   logic [CNT_W-1:0]     clk_cnt;
   logic [BIT_W-1:0]     bit_idx;
   logic [DataWidth-1:0] shift_reg;
   logic                 parity_bit;
   logic                 sym_edge;
   logic                 last_stop;
   logic                 sout_next;
   logic                 sout;

   assign fifo_empty  = (count == '0);
   assign head_word   = mem[rd_ptr];
   assign DataInReady = (count != FULL_COUNT) & ~Reset;
   assign push        = DataInValid & DataInReady;

   assign sym_edge  = (clk_cnt == LAST_CNT);
   assign last_stop = (state == ST_STOP) & sym_edge & (bit_idx == LAST_STOP_BIT);

   // A word leaves the FIFO either from IDLE or directly at the end of the
   // last stop symbol, so consecutive frames are sent with no idle gap.
   assign pop = ~fifo_empty & ((state == ST_IDLE) | last_stop);

   // Parity is taken from the word as it is popped, not from the shifter.
   generate
      if (ParityMode == 2) begin : g_parity_odd
         assign head_parity = ~^head_word;
      end else begin : g_parity_even
         assign head_parity = ^head_word;
      end
   endgenerate

   always_ff @(posedge Clock) begin
      if (push) begin
         mem[wr_ptr] <= DataIn;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               next_state = ST_START;
            end
         end
         ST_START: begin
            if (sym_edge) begin
               next_state = ST_DATA;
            end
         end
         ST_DATA: begin
            if (sym_edge && (bit_idx == LAST_DATA_BIT)) begin
               next_state = (ParityMode != 0) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (sym_edge) begin
               next_state = ST_STOP;
            end
         end
         ST_STOP: begin
            if (last_stop) begin
               next_state = fifo_empty ? ST_IDLE : ST_START;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: output logic (line level for the current symbol)
   // ------------------------------------------------------------------------
   always_comb begin
      sout_next = 1'b1;
      case (state)
         ST_IDLE:   sout_next = 1'b1;
         ST_START:  sout_next = 1'b0;
         ST_DATA:   sout_next = shift_reg[0];
         ST_PARITY: sout_next = parity_bit;
         ST_STOP:   sout_next = 1'b1;
         default:   sout_next = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: symbol timer, bit index, shifter, parity, line register
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         clk_cnt    <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         sout       <= 1'b1;
      end else begin
         sout <= sout_next;

         // The timer only runs inside a frame; IDLE holds it at zero so a
         // fresh START always begins a full symbol.
         if ((state == ST_IDLE) || sym_edge) begin
            clk_cnt <= '0;
         end else begin
            clk_cnt <= clk_cnt + 1'b1;
         end

         // Bit index restarts on every state change and counts symbols
         // within DATA and STOP.
         if (next_state != state) begin
            bit_idx <= '0;
         end else if (sym_edge) begin
            bit_idx <= bit_idx + 1'b1;
         end

         if (pop) begin
            shift_reg  <= head_word;
            parity_bit <= head_parity;
         end else if ((state == ST_DATA) && sym_edge) begin
            shift_reg <= shift_reg >> 1;
         end
      end
   end

   assign SOut      = sout;
   assign Busy      = (state != ST_IDLE) | ~fifo_empty;
   assign FifoCount = count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Bench for uart_tx_fifo. Three instances share one clock:
//                ch0 = 8 data bits, no parity, 1 stop
//                ch1 = 7 data bits, even parity, 2 stop
//                ch2 = 7 data bits, odd parity, 2 stop
//                16 clock cycles per bit on every channel. Accepted words go
//                into a per-channel queue; a UART receiver per channel pops
//                and compares each received frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

   localparam int BIT = 16;

   logic       clk = 1'b0;
   logic [2:0] rst;
   logic [2:0] vld;
   logic [7:0] din0;
   logic [6:0] din1;
   logic [6:0] din2;
   wire  [2:0] rdy;
   wire  [2:0] sout;
   wire  [2:0] busy;
   wire  [3:0] cnt0;
   wire  [3:0] cnt1;
   wire  [3:0] cnt2;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   int          abort_gen [3];
   int          prev_start[3];
   int          last_start[3];
   bit          contig    [3];
   int unsigned q0[$];
   int unsigned q1[$];
   int unsigned q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_fifo #(.ClockFreq(1600), .BaudRate(100), .DataWidth(8), .ParityMode(0),
                  .StopBits(1), .FifoDepth(8)) dut0 (
      .Clock(clk), .Reset(rst[0]), .DataIn(din0), .DataInValid(vld[0]),
      .DataInReady(rdy[0]), .SOut(sout[0]), .Busy(busy[0]), .FifoCount(cnt0));

   uart_tx_fifo #(.ClockFreq(1600), .BaudRate(100), .DataWidth(7), .ParityMode(1),
                  .StopBits(2), .FifoDepth(8)) dut1 (
      .Clock(clk), .Reset(rst[1]), .DataIn(din1), .DataInValid(vld[1]),
      .DataInReady(rdy[1]), .SOut(sout[1]), .Busy(busy[1]), .FifoCount(cnt1));

   uart_tx_fifo #(.ClockFreq(1600), .BaudRate(100), .DataWidth(7), .ParityMode(2),
                  .StopBits(2), .FifoDepth(8)) dut2 (
      .Clock(clk), .Reset(rst[2]), .DataIn(din2), .DataInValid(vld[2]),
      .DataInReady(rdy[2]), .SOut(sout[2]), .Busy(busy[2]), .FifoCount(cnt2));

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   task automatic chk(input string name, input int ch, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s ch%0d: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, ch, act, act, exp, exp, cyc);
      end
   endtask

   function automatic int cnt_of(input int ch);
      case (ch)
         0:       return int'(cnt0);
         1:       return int'(cnt1);
         default: return int'(cnt2);
      endcase
   endfunction

   function automatic int unsigned mask_of(input int ch);
      return (ch == 0) ? 32'hFF : 32'h7F;
   endfunction

   task automatic sb_push(input int ch, input int unsigned v);
      case (ch)
         0:       q0.push_back(v);
         1:       q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   task automatic sb_pop(input int ch, output int unsigned v, output bit ok);
      ok = 1'b0;
      v  = 0;
      case (ch)
         0:       if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
         1:       if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
         default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
      endcase
   endtask

   function automatic int sb_size(input int ch);
      case (ch)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   // Offer one word; returns the edge number at which it was accepted.
   task automatic push(input int ch, input int unsigned v, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      case (ch)
         0:       din0 = v[7:0];
         1:       din1 = v[6:0];
         default: din2 = v[6:0];
      endcase
      vld[ch] = 1'b1;
      while (rdy[ch] !== 1'b1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 4000) begin
         checks++;
         fails++;
         $display("FAIL push_timeout ch%0d: ready stayed low for %0d cycles, expected high", ch, n);
         vld[ch] = 1'b0;
         acc = -1;
      end else begin
         @(posedge clk);
         #1;
         acc = cyc;
         sb_push(ch, v & mask_of(ch));
         vld[ch] = 1'b0;
         // The word is already captured; scramble the bus to prove it.
         case (ch)
            0:       din0 = 8'($urandom);
            1:       din1 = 7'($urandom);
            default: din2 = 7'($urandom);
         endcase
      end
   endtask

   task automatic wait_busy_low(input int ch, output int fall);
      int n;
      n = 0;
      @(negedge clk);
      while (busy[ch] !== 1'b0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         checks++;
         fails++;
         $display("FAIL busy_timeout ch%0d: busy stayed high for %0d cycles, expected low", ch, n);
      end
      fall = cyc;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // ------------------------------------------------------------------------
   // Receiver / scoreboard monitor: one per channel
   // ------------------------------------------------------------------------
   task automatic rx_loop(input int ch);
      int          dw, sb, np, flen, st, ag, nbits;
      bit [15:0]   bits;
      int unsigned word, expv;
      bit          got;
      int          exp_par;
      dw    = (ch == 0) ? 8 : 7;
      sb    = (ch == 0) ? 1 : 2;
      np    = (ch == 0) ? 0 : 1;
      nbits = 1 + dw + np + sb;
      flen  = nbits * BIT;
      forever begin
         @(negedge clk);
         if (sout[ch] === 1'b0) begin
            st = cyc;
            ag = abort_gen[ch];
            repeat (BIT / 2) @(negedge clk);
            bits[0] = sout[ch];
            for (int k = 1; k < nbits; k++) begin
               repeat (BIT) @(negedge clk);
               bits[k] = sout[ch];
            end
            if (ag == abort_gen[ch]) begin
               word = 0;
               for (int i = 0; i < dw; i++) word |= int'(bits[1 + i]) << i;
               sb_pop(ch, expv, got);
               if (!got) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_frame ch%0d: received 0x%0h, expected no frame", ch, word);
               end else begin
                  chk("start_bit", ch, int'(bits[0]), 0);
                  chk("rx_data", ch, int'(word), int'(expv));
                  if (np != 0) begin
                     exp_par = $countones(expv) % 2;
                     if (ch == 2) exp_par = 1 - exp_par;
                     chk("parity_bit", ch, int'(bits[1 + dw]), exp_par);
                  end
                  for (int s = 0; s < sb; s++)
                     chk("stop_bit", ch, int'(bits[1 + dw + np + s]), 1);
                  if (contig[ch] && prev_start[ch] >= 0)
                     chk("frame_spacing", ch, st - prev_start[ch], flen);
               end
               prev_start[ch] = st;
               last_start[ch] = st;
            end
         end
      end
   endtask

   initial rx_loop(0);
   initial rx_loop(1);
   initial rx_loop(2);

   // FIFO occupancy must never exceed its depth.
   always @(negedge clk) begin
      if (cnt0 > 4'd8 || cnt1 > 4'd8 || cnt2 > 4'd8) begin
         checks++;
         fails++;
         $display("FAIL fifo_count_bound: counts %0d/%0d/%0d, expected <= 8", cnt0, cnt1, cnt2);
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      int acc, fall, lows, n;
      int a[10];
      int unsigned w;

      rst  = 3'b111;
      vld  = 3'b000;
      din0 = '0;
      din1 = '0;
      din2 = '0;
      for (int c = 0; c < 3; c++) begin
         abort_gen[c]  = 0;
         prev_start[c] = -1;
         last_start[c] = -1;
         contig[c]     = 1'b0;
      end
      repeat (3) @(negedge clk);
      rst = 3'b000;

      // Idle after reset: line high, not busy, empty, ready.
      repeat (100) begin
         @(negedge clk);
         for (int c = 0; c < 3; c++) begin
            chk("idle_sout", c, int'(sout[c]), 1);
            chk("idle_busy", c, int'(busy[c]), 0);
            chk("idle_count", c, cnt_of(c), 0);
            chk("idle_ready", c, int'(rdy[c]), 1);
         end
      end

      // Single frame 0xA5: start two edges after acceptance, 160-cycle frame.
      push(0, 32'hA5, acc);
      @(negedge clk);
      @(negedge clk);
      chk("latency_n1_sout", 0, int'(sout[0]), 1);
      @(negedge clk);
      chk("latency_n2_sout", 0, int'(sout[0]), 0);
      chk("latency_busy", 0, int'(busy[0]), 1);
      wait_busy_low(0, fall);
      chk("frame_len_busy", 0, fall - acc, 1 + 160);
      chk("start_edge", 0, last_start[0], acc + 2);

      // Ten back-to-back pushes: fills the FIFO, no push-through while full,
      // frames contiguous.
      contig[0]     = 1'b1;
      prev_start[0] = -1;
      for (int i = 0; i < 10; i++) begin
         push(0, $urandom & 32'hFF, a[i]);
         if (i == 8) begin
            chk("full_count", 0, cnt_of(0), 8);
            chk("full_ready", 0, int'(rdy[0]), 0);
         end
      end
      chk("full_accept_edge", 0, a[9], a[0] + 162);
      wait_busy_low(0, fall);
      contig[0] = 1'b0;

      // Push coinciding with a pop at count 4.
      for (int i = 0; i < 5; i++) push(0, $urandom & 32'hFF, a[i]);
      wait_until(a[0] + 159);
      chk("pre_pushpop_count", 0, cnt_of(0), 4);
      push(0, 32'h3C, acc);
      chk("pushpop_edge", 0, acc, a[0] + 161);
      chk("pushpop_count", 0, cnt_of(0), 4);
      wait_busy_low(0, fall);

      // Reset mid-DATA with three words still queued.
      for (int i = 0; i < 4; i++) push(0, $urandom & 32'hFF, a[i]);
      wait_until(a[0] + 60);
      chk("pre_reset_count", 0, cnt_of(0), 3);
      rst[0] = 1'b1;
      sb_flush0();
      abort_gen[0]++;
      @(posedge clk);
      #1;
      chk("reset_sout", 0, int'(sout[0]), 1);
      chk("reset_count", 0, cnt_of(0), 0);
      chk("reset_busy", 0, int'(busy[0]), 0);
      @(negedge clk);
      chk("reset_ready_in_reset", 0, int'(rdy[0]), 0);
      rst[0] = 1'b0;
      #1;
      chk("reset_ready_after", 0, int'(rdy[0]), 1);
      lows = 0;
      repeat (400) begin
         @(negedge clk);
         if (sout[0] !== 1'b1) lows++;
      end
      chk("post_reset_quiet", 0, lows, 0);
      push(0, 32'h5A, acc);
      wait_busy_low(0, fall);
      chk("post_reset_frame_len", 0, fall - acc, 1 + 160);

      // Parity channels: 7'h13 has three ones.
      push(1, 32'h13, acc);
      wait_busy_low(1, fall);
      chk("parity_even_frame_len", 1, fall - acc, 1 + 176);
      push(2, 32'h13, acc);
      wait_busy_low(2, fall);
      chk("parity_odd_frame_len", 2, fall - acc, 1 + 176);

      // Random traffic on all channels concurrently.
      fork
         begin
            int ac;
            for (int i = 0; i < 20; i++) begin
               repeat ($urandom_range(0, 200)) @(negedge clk);
               push(0, $urandom, ac);
            end
         end
         begin
            int ac;
            for (int i = 0; i < 8; i++) begin
               repeat ($urandom_range(0, 250)) @(negedge clk);
               push(1, $urandom, ac);
            end
         end
         begin
            int ac;
            for (int i = 0; i < 8; i++) begin
               repeat ($urandom_range(0, 250)) @(negedge clk);
               push(2, $urandom, ac);
            end
         end
      join

      // Drain: every accepted word must have been received.
      n = 0;
      while ((busy !== 3'b000 || sb_size(0) + sb_size(1) + sb_size(2) != 0) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) begin
         checks++;
         fails++;
         $display("FAIL drain_timeout: busy=%b queued=%0d/%0d/%0d, expected idle and empty",
                  busy, sb_size(0), sb_size(1), sb_size(2));
      end
      for (int c = 0; c < 3; c++) begin
         chk("drain_queue_empty", c, sb_size(c), 0);
         chk("drain_sout", c, int'(sout[c]), 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   task automatic sb_flush0();
      q0.delete();
   endtask

endmodule
`default_nettype wire
